i2c_config_sequencer: RTL and testbench



---
 rtl/i2c_seq_pkg.sv | 27 ++
 rtl/i2c_config_rom.sv | 27 ++
 rtl/i2c_config_sequencer.sv | 155 +++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_seq_pkg;

   localparam int I2C_WORD_W     = 24;
   localparam int ROM_W          = 16;
   localparam int INDEX_W        = 6;
   localparam int MAX_REGS       = 64;
   localparam int MIN_GAP_CYCLES = 3;
   localparam int TIMEOUT_W      = 12;
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = 12'd4095;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_KICK,
      ST_WAIT_DONE,
      ST_GAP,
      ST_FINISH,
      ST_FAIL
   } state_t;

   function automatic logic [I2C_WORD_W-1:0] make_word(input logic [7:0] dev_addr,
                                                      input logic [ROM_W-1:0] entry);
      return {dev_addr, entry};
   endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Fixed codec register table: index -> {sub_addr, data}. Unlisted indices read as zero.
module i2c_config_rom
   import i2c_seq_pkg::*;
(
   input  logic [INDEX_W-1:0] index,
   output logic [ROM_W-1:0]   entry
);

   always_comb begin
      // NOTE: default assignment first so every path drives entry and no latch is inferred.
      entry = '0;
      case (index)
         6'd0:    entry = 16'h1E00;
         6'd1:    entry = 16'h0017;
         6'd2:    entry = 16'h0217;
         6'd3:    entry = 16'h0479;
         6'd4:    entry = 16'h0679;
         6'd5:    entry = 16'h0812;
         6'd6:    entry = 16'h0A00;
         6'd7:    entry = 16'h0C00;
         6'd8:    entry = 16'h0E42;
         6'd9:    entry = 16'h1001;
         default: entry = '0;
      endcase
   end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the register table and drives the byte-serial I2C controller, retrying NACKed entries.
// Optional WAIT_DONE watchdog with TIMEOUT pulse when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_config_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int         NUM_REGS   = 10,
   parameter logic [7:0] DEV_ADDR   = 8'h34,
   parameter int         RETRY_MAX  = 3,
   parameter int         GAP_CYCLES = 16
)
(
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  START,
   output logic [I2C_WORD_W-1:0] I2C_DATA_REG,
   output logic                  I2C_START_TX,
   input  logic                  I2C_TX_DONE,
   input  logic                  I2C_ACK,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR,
`ifdef I2C_SEQ_TIMEOUT_EN
   output logic                  TIMEOUT,
`endif
   output logic [INDEX_W-1:0]    CUR_INDEX
);

   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
   localparam logic [3:0]         RETRY_LIMIT = 4'(RETRY_MAX);
   localparam logic [INDEX_W-1:0] LAST_INDEX  = INDEX_W'(NUM_REGS - 1);

   if (NUM_REGS < 1 || NUM_REGS > MAX_REGS) begin : g_num_regs_check
      $error("i2c_config_sequencer: NUM_REGS must be in 1..64");
   end
   if (RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_retry_check
      $error("i2c_config_sequencer: RETRY_MAX must be in 1..15");
   end
   if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_gap_check
      $error("i2c_config_sequencer: GAP_CYCLES must be at least 3");
   end

   state_t             state;
   logic [3:0]         retry_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [ROM_W-1:0]   rom_entry;
   logic               wdog_expired;

`ifdef I2C_SEQ_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog_cnt;
   assign wdog_expired = (wdog_cnt == TIMEOUT_LIMIT - 1'b1);
`else
   assign wdog_expired = 1'b0;
`endif

   i2c_config_rom u_rom (
      .index (CUR_INDEX),
      .entry (rom_entry)
   );

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state        <= ST_IDLE;
         I2C_DATA_REG <= '0;
         I2C_START_TX <= 1'b0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERROR        <= 1'b0;
         CUR_INDEX    <= '0;
         retry_cnt    <= '0;
         gap_cnt      <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
         wdog_cnt     <= '0;
         TIMEOUT      <= 1'b0;
`endif
      end else begin
         I2C_START_TX <= 1'b0;
         DONE         <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
         TIMEOUT      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (START) begin
                  ERROR     <= 1'b0;
                  CUR_INDEX <= '0;
                  retry_cnt <= '0;
                  BUSY      <= 1'b1;
                  state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               I2C_DATA_REG <= make_word(DEV_ADDR, rom_entry);
               state        <= ST_KICK;
            end
            ST_KICK: begin
               I2C_START_TX <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
               wdog_cnt     <= '0;
`endif
               state        <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               // A real completion wins over a watchdog expiry landing in the same cycle.
               if (I2C_TX_DONE || wdog_expired) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                  TIMEOUT <= ~I2C_TX_DONE;
`endif
                  if (I2C_TX_DONE && I2C_ACK) begin
                     retry_cnt <= '0;
                     if (CUR_INDEX == LAST_INDEX) begin
                        state <= ST_FINISH;
                     end else begin
                        CUR_INDEX <= CUR_INDEX + 1'b1;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                     end
                  end else if (retry_cnt + 4'd1 == RETRY_LIMIT) begin
                     state <= ST_FAIL;
                  end else begin
                     retry_cnt <= retry_cnt + 4'd1;
                     gap_cnt   <= '0;
                     state     <= ST_GAP;
                  end
               end
`ifdef I2C_SEQ_TIMEOUT_EN
               else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_LOAD;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            ST_FINISH: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_FAIL: begin
               ERROR <= 1'b1;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized self-checking bench: a controller responder plus a table-walk reference model.
module tb_i2c_config_sequencer;

   localparam int         NUM_REGS   = 3;
   localparam int         RETRY_MAX  = 3;
   localparam int         GAP_CYCLES = 16;
   localparam logic [7:0] DEV        = 8'h34;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [23:0] data_reg;
   logic        start_tx;
   logic        tx_done;
   logic        ack;
   logic        busy;
   logic        done;
   logic        error;
   logic [5:0]  cur_index;
`ifdef I2C_SEQ_TIMEOUT_EN
   logic        timeout;
`endif

   always #5 clk = ~clk;

   i2c_config_sequencer #(
      .NUM_REGS   (NUM_REGS),
      .DEV_ADDR   (DEV),
      .RETRY_MAX  (RETRY_MAX),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .CLOCK        (clk),
      .RESET        (rst),
      .START        (start),
      .I2C_DATA_REG (data_reg),
      .I2C_START_TX (start_tx),
      .I2C_TX_DONE  (tx_done),
      .I2C_ACK      (ack),
      .BUSY         (busy),
      .DONE         (done),
      .ERROR        (error),
`ifdef I2C_SEQ_TIMEOUT_EN
      .TIMEOUT      (timeout),
`endif
      .CUR_INDEX    (cur_index)
   );

   logic [15:0] rom_tbl [0:9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                  16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1001};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Monitor-owned observations
   logic [23:0] obs_words[$];
   int          obs_cyc[$];
   int          done_cnt  = 0;
   int          width_err = 0;
   int          to_cnt    = 0;
   int          to_first  = 0;
   bit          prev_start = 1'b0;

   // Responder-owned
   int          resp_n = 0;

   // Main-owned controls for the responder
   bit          ack_script[$];
   int          script_base = 0;
   bit          respond_en  = 1'b1;
   int          lat_lo      = 32;
   int          lat_hi      = 32;

   // Reference model results
   int          exp_idx[$];
   bit          exp_done;
   bit          exp_err;
   int          exp_last;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         if (start_tx) begin
            obs_words.push_back(data_reg);
            obs_cyc.push_back(cyc);
            if (prev_start) width_err++;
         end
         prev_start = start_tx;
         if (done) done_cnt++;
`ifdef I2C_SEQ_TIMEOUT_EN
         if (timeout) begin
            if (to_cnt == 0) to_first = cyc;
            to_cnt++;
         end
`endif
      end
   end

   initial begin
      int pos;
      bit a;
      tx_done = 1'b0;
      ack     = 1'b0;
      forever begin
         @(negedge clk);
         if (start_tx && respond_en) begin
            pos = resp_n - script_base;
            a   = (pos >= 0 && pos < ack_script.size()) ? ack_script[pos] : 1'b1;
            resp_n++;
            repeat ($urandom_range(lat_hi, lat_lo)) @(negedge clk);
            tx_done = 1'b1;
            ack     = a;
            @(negedge clk);
            tx_done = 1'b0;
            ack     = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Table walk from the rules: each attempt consumes one ack; acks advance, NACKs count toward the limit.
   function automatic void model();
      int e = 0;
      int tries = 0;
      int k = 0;
      bit a;
      exp_idx.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      while (k < 1000) begin
         a = (k < ack_script.size()) ? ack_script[k] : 1'b1;
         k++;
         exp_idx.push_back(e);
         if (a) begin
            tries = 0;
            if (e == NUM_REGS - 1) begin
               exp_done = 1'b1;
               break;
            end
            e++;
         end else begin
            tries++;
            if (tries == RETRY_MAX) begin
               exp_err = 1'b1;
               break;
            end
         end
      end
      exp_last = e;
   endfunction

   task automatic run_seq(input string tag, input int hold, input bit chk_lat,
                          input bit extra_pulse, input int bound);
      int i = 0;
      bit seen_idle = 1'b0;
      int ob, db, n_obs, min_sep, d;
      model();
      script_base = resp_n;
      ob = obs_words.size();
      db = done_cnt;
      d  = width_err;
      @(negedge clk);
      start = 1'b1;
      while (i < bound && !seen_idle) begin
         @(negedge clk);
         i++;
         if (i == hold) start = 1'b0;
         if (extra_pulse && i == 30) start = 1'b1;
         if (extra_pulse && i == 31) start = 1'b0;
         if (i == 1) begin
            check({tag, " busy_on_start"}, busy, 1'b1);
            check({tag, " error_cleared"}, error, 1'b0);
         end
         if (chk_lat && i == 2) begin
            check({tag, " no_pulse_before_latency"}, start_tx, 1'b0);
            check({tag, " word_before_pulse"}, data_reg, {DEV, rom_tbl[0]});
         end
         if (chk_lat && i == 3) check({tag, " pulse_at_latency3"}, start_tx, 1'b1);
         if (i > 1 && !busy) seen_idle = 1'b1;
      end
      start = 1'b0;
      check({tag, " busy_low_in_bound"}, busy, 1'b0);
      repeat (3) @(negedge clk);
      n_obs = obs_words.size() - ob;
      check({tag, " pulse_count"}, n_obs, exp_idx.size());
      for (int k = 0; k < exp_idx.size() && k < n_obs; k++)
         check($sformatf("%s word%0d", tag, k), obs_words[ob + k], {DEV, rom_tbl[exp_idx[k]]});
      check({tag, " done_pulses"}, done_cnt - db, exp_done);
      check({tag, " error"}, error, exp_err);
      check({tag, " cur_index"}, cur_index, exp_last);
      check({tag, " pulse_width"}, width_err - d, 0);
      if (n_obs >= 2) begin
         min_sep = 1 << 30;
         for (int k = 1; k < n_obs; k++)
            if (obs_cyc[ob + k] - obs_cyc[ob + k - 1] < min_sep)
               min_sep = obs_cyc[ob + k] - obs_cyc[ob + k - 1];
         check({tag, " pulse_spacing_ok"}, min_sep >= GAP_CYCLES + 2, 1'b1);
      end
   endtask

   initial begin
      int ob, db, w;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset data_reg", data_reg, 24'h0);
      check("reset start_tx", start_tx, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset error", error, 1'b0);
      check("reset cur_index", cur_index, 6'd0);
`ifdef I2C_SEQ_TIMEOUT_EN
      check("reset timeout", timeout, 1'b0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean run with fixed controller latency and the START->pulse latency checked
      ack_script = '{1, 1, 1};
      run_seq("clean", 1, 1'b1, 1'b0, 5000);

      // Entry 1 NACKed once
      ack_script = '{1, 0, 1, 1};
      run_seq("nack_once", 1, 1'b0, 1'b0, 5000);

      // Entry 2 never acked, then a clean run clears the sticky error
      ack_script = '{1, 1, 0, 0, 0};
      run_seq("entry2_fail", 1, 1'b0, 1'b0, 5000);
      check("entry2_fail error_sticky", error, 1'b1);
      ack_script = '{1, 1, 1};
      run_seq("after_fail", 1, 1'b0, 1'b0, 5000);

      // START held 5 cycles and re-pulsed while busy
      ack_script = '{1, 1, 1};
      run_seq("start_held", 5, 1'b0, 1'b1, 5000);

      // Randomized ack patterns and controller latencies
      lat_lo = 1;
      lat_hi = 40;
      for (int r = 0; r < 8; r++) begin
         ack_script.delete();
         for (int k = 0; k < NUM_REGS * RETRY_MAX + 2; k++)
            ack_script.push_back($urandom_range(99, 0) >= 35);
         run_seq($sformatf("rand%0d", r), 1, 1'b0, 1'b0, 5000);
      end

      // RESET while waiting on entry 1; the controller still completes afterwards
      lat_lo = 32;
      lat_hi = 32;
      ack_script = '{1, 1, 1};
      script_base = resp_n;
      ob = obs_words.size();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (obs_words.size() < ob + 2 && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("rst_mid second_pulse_seen", obs_words.size() - ob, 2);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid data_reg", data_reg, 24'h0);
      check("rst_mid start_tx", start_tx, 1'b0);
      check("rst_mid busy", busy, 1'b0);
      check("rst_mid done", done, 1'b0);
      check("rst_mid error", error, 1'b0);
      check("rst_mid cur_index", cur_index, 6'd0);
      rst = 1'b0;
      db = done_cnt;
      repeat (45) @(negedge clk);
      check("rst_mid stray_no_pulse", obs_words.size() - ob, 2);
      check("rst_mid stray_no_done", done_cnt - db, 0);
      check("rst_mid stray_idle", busy, 1'b0);
      ack_script = '{1, 1, 1};
      run_seq("after_reset", 1, 1'b1, 1'b0, 5000);

`ifdef I2C_SEQ_TIMEOUT_EN
      // Controller never answers: every attempt ends by watchdog
      respond_en = 1'b0;
      ack_script = '{0, 0, 0};
      ob = obs_words.size();
      run_seq("timeout", 1, 1'b0, 1'b0, 20000);
      check("timeout pulses", to_cnt, RETRY_MAX);
      if (obs_words.size() > ob)
         check("timeout first_delay", to_first - obs_cyc[ob], 4095);
      respond_en = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
